// File: rtl/usi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usi_pkg : shared USI bus encodings, block IDs and register map   (rev 1.0)
// ---------------------------------------------------------------------------
package usi_pkg;

  localparam int USI_ADRS_BIT = 16;
  localparam int USI_RW_BIT   = USI_ADRS_BIT - 1;

  typedef enum logic {
    USI_CMD_RD = 1'b0,
    USI_CMD_WR = 1'b1
  } usi_cmd_e;

  // Block numbers as seen in the address block-select field
  localparam int BLK_ID_MCU = 0;
  localparam int BLK_ID_CSR = 1;
  localparam int BLK_ID_DMA = 2;
  localparam int BLK_ID_TMR = 3;

  localparam int REG_ID       = 0;
  localparam int REG_STAT     = 1;
  localparam int REG_FIRST_RW = 2;

  localparam int USI_RD_LAT = 2;

endpackage
`default_nettype wire

// File: rtl/usi_csr_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usi_csr_slave_if : USI command / read-response bundle            (rev 1.0)
// ---------------------------------------------------------------------------
interface usi_csr_slave_if #(
  parameter int pBusAdrsBit = 16
);

  logic [31:0]            SUsiWd;
  logic [pBusAdrsBit-1:0] SUsiAdrs;
  logic                   SUsiWEd;
  logic [31:0]            SUsiRd;
  logic                   SUsiREd;

  modport master (
    output SUsiWd,
    output SUsiAdrs,
    output SUsiWEd,
    input  SUsiRd,
    input  SUsiREd
  );

  modport slave (
    input  SUsiWd,
    input  SUsiAdrs,
    input  SUsiWEd,
    output SUsiRd,
    output SUsiREd
  );

endinterface
`default_nettype wire

// File: rtl/usi_csr_slave_adrs_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usi_adrs_dec : USI hit/RW/index decode with registered read stage (rev 1.0)
// ---------------------------------------------------------------------------
module usi_adrs_dec
  import usi_pkg::*;
#(
  parameter int pBusAdrsBit = 16,
  parameter int pBlkIdBit   = 4,
  parameter int pBlkId      = 1,
  parameter int pRegIdxBit  = 3
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [pBusAdrsBit-1:0] iAdrs,
  input  logic                   iWEd,
  output logic                   oWrHit,
  output logic [pRegIdxBit-1:0]  oWrIdx,
  output logic                   oRdVld,
  output logic [pRegIdxBit-1:0]  oRdIdx
);

  logic                  w_hit;
  logic                  w_is_wr;
  logic [pRegIdxBit-1:0] w_idx;
  logic                  w_unused_adrs;

  logic                  rd_vld_q, rd_vld_d;
  logic [pRegIdxBit-1:0] rd_idx_q, rd_idx_d;

  // Bits between the index and block fields are don't-care, so registers alias
  assign w_unused_adrs = ^iAdrs[pBusAdrsBit-pBlkIdBit-2:pRegIdxBit];

  assign w_hit   = iWEd && (iAdrs[pBusAdrsBit-2 -: pBlkIdBit] == pBlkIdBit'(pBlkId));
  assign w_is_wr = (iAdrs[pBusAdrsBit-1] == USI_CMD_WR);
  assign w_idx   = iAdrs[pRegIdxBit-1:0];

  // Writes must land on the command edge, so their strobe is left unregistered
  assign oWrHit = w_hit && w_is_wr;
  assign oWrIdx = w_idx;

  always_comb begin
    rd_vld_d = w_hit && !w_is_wr;
    rd_idx_d = rd_vld_d ? w_idx : rd_idx_q;
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  assign oRdVld = rd_vld_q;
  assign oRdIdx = rd_idx_q;

endmodule
`default_nettype wire

// File: rtl/usi_csr_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usi_csr_slave : USI responder owning one block's CSR bank         (rev 1.0)
// ---------------------------------------------------------------------------
module usi_csr_slave
  import usi_pkg::*;
#(
  parameter int          pBusAdrsBit = 16,
  parameter int          pBlkIdBit   = 4,
  parameter int          pBlkId      = 1,
  parameter int          pRegIdxBit  = 3,
  parameter logic [31:0] pIdValue    = 32'h0000_A701,
  localparam int         pRegNum     = 2 ** pRegIdxBit
) (
  input  logic                      iSysClk,
  input  logic                      iSysRst,
  usi_csr_slave_if.slave            usi,
  input  logic [31:0]               iStatEvt,
  output logic [32*(pRegNum-2)-1:0] oCsrReg,
  output logic [pRegNum-1:0]        oCsrWp
);

  logic                  w_wr_hit;
  logic [pRegIdxBit-1:0] w_wr_idx;
  logic                  w_rd_vld;
  logic [pRegIdxBit-1:0] w_rd_idx;
  logic [31:0]           w_stat_clr;
  logic [31:0]           w_rd_val;

  logic [pRegNum-1:2][31:0] csr_q, csr_d;
  logic [31:0]              stat_q, stat_d;
  logic [pRegNum-1:0]       wp_q, wp_d;
  logic [31:0]              rd_q, rd_d;
  logic                     red_q, red_d;

  usi_adrs_dec #(
    .pBusAdrsBit (pBusAdrsBit),
    .pBlkIdBit   (pBlkIdBit),
    .pBlkId      (pBlkId),
    .pRegIdxBit  (pRegIdxBit)
  ) u_dec (
    .iSysClk (iSysClk),
    .iSysRst (iSysRst),
    .iAdrs   (usi.SUsiAdrs),
    .iWEd    (usi.SUsiWEd),
    .oWrHit  (w_wr_hit),
    .oWrIdx  (w_wr_idx),
    .oRdVld  (w_rd_vld),
    .oRdIdx  (w_rd_idx)
  );

  always_comb begin
    csr_d      = csr_q;
    wp_d       = '0;
    w_stat_clr = '0;
    if (w_wr_hit) begin
      wp_d[w_wr_idx] = 1'b1;
      if (w_wr_idx == pRegIdxBit'(REG_STAT)) begin
        w_stat_clr = usi.SUsiWd;
      end else if (w_wr_idx >= pRegIdxBit'(REG_FIRST_RW)) begin
        csr_d[w_wr_idx] = usi.SUsiWd;
      end
    end
    // A new event on a bit outranks a simultaneous write-1-to-clear
    stat_d = (stat_q & ~w_stat_clr) | iStatEvt;
  end

  always_comb begin
    w_rd_val = '0;
    if (w_rd_idx == pRegIdxBit'(REG_ID)) begin
      w_rd_val = pIdValue;
    end else if (w_rd_idx == pRegIdxBit'(REG_STAT)) begin
      w_rd_val = stat_q;
    end else if (w_rd_idx >= pRegIdxBit'(REG_FIRST_RW)) begin
      w_rd_val = csr_q[w_rd_idx];
    end
    red_d = w_rd_vld;
    rd_d  = w_rd_vld ? w_rd_val : '0;
  end

  // Idle data is forced to zero so several slaves can be OR-merged
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      csr_q  <= '0;
      stat_q <= '0;
      wp_q   <= '0;
      rd_q   <= '0;
      red_q  <= 1'b0;
    end else begin
      csr_q  <= csr_d;
      stat_q <= stat_d;
      wp_q   <= wp_d;
      rd_q   <= rd_d;
      red_q  <= red_d;
    end
  end

  assign oCsrReg     = csr_q;
  assign oCsrWp      = wp_q;
  assign usi.SUsiRd  = rd_q;
  assign usi.SUsiREd = red_q;

endmodule
`default_nettype wire

// File: tb/tb_usi_csr_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usi_csr_slave : scoreboard bench for usi_csr_slave             (rev 1.0)
// ---------------------------------------------------------------------------
module tb_usi_csr_slave;

  localparam logic [31:0] ID_VAL = 32'h0000_A701;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  stat_evt;
  logic [191:0] csr_reg;
  logic [7:0]   csr_wp;

  usi_csr_slave_if #(.pBusAdrsBit(16)) u_bus ();

  usi_csr_slave #(
    .pBusAdrsBit (16),
    .pBlkIdBit   (4),
    .pBlkId      (1),
    .pRegIdxBit  (3),
    .pIdValue    (ID_VAL)
  ) u_dut (
    .iSysClk  (clk),
    .iSysRst  (rst),
    .usi      (u_bus),
    .iStatEvt (stat_evt),
    .oCsrReg  (csr_reg),
    .oCsrWp   (csr_wp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q[$];
  logic [31:0] cur_reg [8];
  logic [31:0] nxt_reg [8];
  logic [7:0]  cur_wp, nxt_wp;
  logic        cur_valid, nxt_valid;
  int          cyc;
  int          n_chk;
  int          n_err;

  function automatic logic [191:0] flat_regs();
    logic [191:0] f;
    f = '0;
    for (int k = 2; k < 8; k++) f[32*(k-2) +: 32] = cur_reg[k];
    return f;
  endfunction

  // One bus cycle: drive inputs and advance the architectural model
  task automatic step(input logic r, input logic wed, input logic [15:0] adrs,
                      input logic [31:0] wd, input logic [31:0] evt);
    logic hit;
    logic wr;
    int   idx;
    @(posedge clk);
    #1;
    cyc++;
    cur_reg   = nxt_reg;
    cur_wp    = nxt_wp;
    cur_valid = nxt_valid;
    rst            = r;
    u_bus.SUsiWEd  = wed;
    u_bus.SUsiAdrs = adrs;
    u_bus.SUsiWd   = wd;
    stat_evt       = evt;
    if (r) begin
      for (int i = 0; i < 8; i++) nxt_reg[i] = '0;
      nxt_reg[0] = ID_VAL;
      nxt_wp     = '0;
      nxt_valid  = 1'b1;
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    end else begin
      hit = wed && (adrs[14:11] == 4'd1);
      wr  = adrs[15];
      idx = int'(adrs[2:0]);
      nxt_reg    = cur_reg;
      nxt_reg[1] = (cur_reg[1] & ~((hit && wr && idx == 1) ? wd : 32'h0)) | evt;
      if (hit && wr && idx >= 2) nxt_reg[idx] = wd;
      nxt_wp = (hit && wr) ? (8'b1 << idx) : 8'b0;
      if (hit && !wr) q.push_back('{due: cyc + 2, data: nxt_reg[idx]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        n_chk++;
        if (u_bus.SUsiREd !== 1'b1) begin
          n_err++;
          $display("FAIL rd_valid cyc=%0d got=%b want=1", cyc, u_bus.SUsiREd);
        end
        n_chk++;
        if (u_bus.SUsiRd !== q[0].data) begin
          n_err++;
          $display("FAIL rd_data cyc=%0d got=%h want=%h", cyc, u_bus.SUsiRd, q[0].data);
        end
        void'(q.pop_front());
      end else begin
        n_chk++;
        if (u_bus.SUsiREd !== 1'b0 || u_bus.SUsiRd !== 32'h0) begin
          n_err++;
          $display("FAIL rd_idle cyc=%0d got vld=%b data=%h want vld=0 data=0",
                   cyc, u_bus.SUsiREd, u_bus.SUsiRd);
        end
      end
      n_chk++;
      if (csr_reg !== flat_regs()) begin
        n_err++;
        $display("FAIL csr_reg cyc=%0d got=%h want=%h", cyc, csr_reg, flat_regs());
      end
      n_chk++;
      if (csr_wp !== cur_wp) begin
        n_err++;
        $display("FAIL csr_wp cyc=%0d got=%b want=%b", cyc, csr_wp, cur_wp);
      end
    end
  end

  initial begin
    logic [3:0]  blk;
    logic [15:0] adrs;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    cur_valid = 1'b0;
    nxt_valid = 1'b0;
    cur_wp    = '0;
    nxt_wp    = '0;
    for (int i = 0; i < 8; i++) begin
      cur_reg[i] = '0;
      nxt_reg[i] = '0;
    end
    rst            = 1'b1;
    stat_evt       = '0;
    u_bus.SUsiWEd  = 1'b0;
    u_bus.SUsiAdrs = '0;
    u_bus.SUsiWd   = '0;

    step(1'b1, 1'b0, 16'h0000, 32'h0, 32'h0);
    step(1'b1, 1'b0, 16'h0000, 32'h0, 32'h0);
    idle(2);

    // ID register read
    step(1'b0, 1'b1, 16'h0800, 32'h0, 32'h0);
    idle(3);

    // Write reg 3, then read-after-write
    step(1'b0, 1'b1, 16'h8803, 32'hDEAD_BEEF, 32'h0);
    step(1'b0, 1'b1, 16'h0803, 32'h0, 32'h0);
    idle(3);

    // Sticky status, set-wins collision, then a plain clear
    step(1'b0, 1'b0, 16'h0000, 32'h0, 32'h5);
    step(1'b0, 1'b1, 16'h8801, 32'h1, 32'h1);
    step(1'b0, 1'b1, 16'h0801, 32'h0, 32'h0);
    step(1'b0, 1'b1, 16'h8801, 32'h4, 32'h0);
    step(1'b0, 1'b1, 16'h0801, 32'h0, 32'h0);
    idle(3);

    // Other block: ignored
    step(1'b0, 1'b1, 16'h9003, 32'h1234_5678, 32'h0);
    step(1'b0, 1'b1, 16'h1003, 32'h0, 32'h0);
    idle(3);

    // Back-to-back reads, aliased middle bits on one of them
    step(1'b0, 1'b1, 16'h0800, 32'h0, 32'h0);
    step(1'b0, 1'b1, 16'h0801, 32'h0, 32'h0);
    step(1'b0, 1'b1, 16'h0802, 32'h0, 32'h0);
    step(1'b0, 1'b1, 16'h0FFB, 32'h0, 32'h0);
    idle(3);

    // Reset while a read is in flight
    step(1'b0, 1'b1, 16'h0803, 32'h0, 32'h0);
    step(1'b1, 1'b0, 16'h0000, 32'h0, 32'h0);
    idle(4);

    for (int n = 0; n < 3000; n++) begin
      blk  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
      adrs = {1'($urandom), blk, 8'($urandom), 3'($urandom)};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), adrs,
           $urandom, $urandom & $urandom & $urandom);
    end
    idle(4);

    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d outstanding want=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
